// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - pending register write-back FIFO with read-port bypass
//
// Purpose: buffers {addr, data} results until the register array write port is
// free, writes them back in arrival order, and lets both read ports see the
// newest still-pending value for their address.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     producer handshake; in_addr/in_data carry the result
//   drain_en              array write port free this cycle
//   wr_enable/addr/data   write port drive (head entry)
//   rd_addr1/rd_addr2     addresses on the array read ports
//   byp_hit1/2, byp_data1/2  newest pending value for each read address
//   count                 occupied entries, 0..DEPTH

module reg_writeback_queue #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              drain_en,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_enable,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              byp_hit1,
    output logic              byp_hit2,
    output logic [DATA_W-1:0] byp_data1,
    output logic [DATA_W-1:0] byp_data2,
    output logic [ADDR_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic push;
    logic pop;
    logic [DATA_W:0] look1;
    logic [DATA_W:0] look2;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Walk entries oldest to newest so the last match (nearest the tail) wins.
    // Only stored entries are searched; the current in_* result is not visible.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
        logic [DATA_W:0]  r;
        logic [PTR_W-1:0] idx;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) && (addr_q[idx] == a)) begin
                r = {1'b1, data_q[idx]};
            end
        end
        return r;
    endfunction

    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign wr_enable = (count_q != '0) && drain_en;
    assign wr_addr   = (count_q != '0) ? addr_q[head_q] : '0;
    assign wr_data   = (count_q != '0) ? data_q[head_q] : '0;
    assign count     = ADDR_W'(count_q);

    assign push = in_valid && in_ready;
    assign pop  = wr_enable;

    always_comb begin
        look1     = lookup(rd_addr1);
        look2     = lookup(rd_addr2);
        byp_hit1  = look1[DATA_W];
        byp_data1 = look1[DATA_W-1:0];
        byp_hit2  = look2[DATA_W];
        byp_data2 = look2[DATA_W-1:0];
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) begin
            addr_d[tail_q] = in_addr;
            data_d[tail_q] = in_data;
            tail_d         = next_ptr(tail_q);
        end
        if (pop) begin
            head_d = next_ptr(head_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: doc/reg_writeback_queue.md
REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter DATA_W, 32: width of a register value.
REQ-003 Parameter ADDR_W, 3: width of a register address (8 registers).
REQ-004 Parameter DEPTH, 4: number of pending-write entries (power of two).
REQ-005 clk  input  1  rising-edge clock shared with the register array.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  producer offers a result.
REQ-008 in_ready  output  1  queue accepts a result this cycle.
REQ-009 in_data  input  DATA_W  result value.
REQ-010 in_addr  input  ADDR_W  destination register.
REQ-011 drain_en  input  1  register array write port available this cycle.
REQ-012 wr_data  output  DATA_W  to register array input data.
REQ-013 wr_addr  output  ADDR_W  to register array input address.
REQ-014 wr_enable  output  1  to register array write enable.
REQ-015 rd_addr1 / rd_addr2  input  ADDR_W each  addresses currently driven on the array's two read ports.
REQ-016 byp_hit1 / byp_hit2  output  1 each  a pending write targets the matching rd_addr.
REQ-017 byp_data1 / byp_data2  output  DATA_W each  newest pending value for the matching rd_addr.
REQ-018 count  output  ADDR_W  number of occupied entries, 0..DEPTH.

Function
REQ-019 Storage SHALL be a circular FIFO of DEPTH {addr, data} entries with head and tail pointers that wrap from DEPTH-1 to 0.
REQ-020 in_ready SHALL be high exactly when count < DEPTH (combinational from registered count).
REQ-021 Push: on a rising edge with in_valid & in_ready, {in_addr, in_data} SHALL be stored at the tail and the tail advanced.
REQ-022 wr_addr/wr_data SHALL equal the head entry combinationally; they SHALL be 0 when count = 0.
REQ-023 wr_enable SHALL be (count != 0) & drain_en; on a rising edge with wr_enable high, the head entry SHALL be popped on the same edge on which the array writes it.
REQ-024 Latency: a result pushed at edge N SHALL appear on wr_enable at the earliest between edges N and N+1; a push into an empty queue never writes on the same edge.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve order; when full, the push is refused (in_ready low) even if a pop occurs.
REQ-026 Writes SHALL leave in FIFO order; duplicate addresses are kept as separate entries, never merged.
REQ-027 Bypass: byp_hitK SHALL be high when any occupied entry has addr = rd_addrK; byp_dataK SHALL be the data of the newest such entry (nearest the tail), otherwise 0.
REQ-028 Bypass SHALL consider stored entries only, not the in_* inputs of the current cycle.
REQ-029 An entry popped at an edge SHALL no longer produce a hit after that edge.
REQ-030 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or underflow.

Reset
REQ-031 While rst is high, head, tail and count SHALL be 0, all pending entries SHALL be discarded, wr_enable = 0, in_ready = 1, and byp_hit1/2 = 0.
REQ-032 Reset asserted mid-operation SHALL drop every unwritten entry without any further wr_enable pulse.

Verification
REQ-033 Push {3, DEADBEEF} with drain_en = 0 -> count = 1, wr_enable = 0, rd_addr1 = 3 gives byp_hit1 = 1, byp_data1 = DEADBEEF.
REQ-034 Push {0, ACEDCAFE}, {7, DEADBEEF}, {7, FFFFFFFF} with drain_en = 0, then rd_addr2 = 7 -> byp_data2 = FFFFFFFF; raise drain_en -> wr_addr/wr_data sequence 0/ACEDCAFE, 7/DEADBEEF, 7/FFFFFFFF on consecutive edges, then count = 0.
REQ-035 Fill 4 entries -> in_ready = 0 and a fifth push is ignored; with in_valid and drain_en both high for 6 edges -> count stays at 4 or below, order is preserved, and the pointers wrap correctly.
REQ-036 Push with drain_en = 1 into an empty queue -> wr_enable = 0 before the edge and 1 in the next cycle, with one-entry latency.
REQ-037 Load 3 entries and pulse rst between edges -> count, wr_enable and byp_hit drop to 0 immediately, and no stale write follows release.
